// File: rtl/card_dealer.sv
// Purpose: deals pseudo-random cards alternately to two players at a fixed period, freezes while hold is high, stops when the deck runs out.
// Latency: first deal pulse PERIOD cycles after the start edge, then one every PERIOD cycles plus one cycle per held WAIT cycle; all outputs registered.
// Backpressure: hold freezes the deal timer in WAIT; start is honoured only from IDLE/DONE and ignored while busy.
module card_dealer #(
  parameter int unsigned PERIOD    = 50000000,
  parameter int unsigned MAX_CARDS = 56,
  parameter logic [7:0]  SEED      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hold,
  output logic [4:0] value_player1,
  output logic [4:0] value_player2,
  output logic       random_enable,
  output logic       turn,
  output logic [7:0] cards_left,
  output logic       deck_empty,
  output logic       busy
);

  // Timer reload: the WAIT->DEAL decision plus the DEAL cycle itself account
  // for the two cycles not covered by the countdown.
  localparam logic [31:0] TIMER_RELOAD = 32'(PERIOD - 2);
  localparam logic [7:0]  DECK_SIZE    = 8'(MAX_CARDS);
  // An all-zero LFSR would lock up, so a zero seed is forced to 1.
  localparam logic [7:0]  LFSR_INIT    = (SEED == 8'h00) ? 8'h01 : SEED;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DEAL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] timer, timer_nxt;
  logic [7:0]  lfsr, lfsr_nxt;
  logic [4:0]  value_player1_nxt;
  logic [4:0]  value_player2_nxt;
  logic        random_enable_nxt;
  logic        turn_nxt;
  logic [7:0]  cards_left_nxt;
  logic [7:0]  cards_left_dec;
  logic        deck_empty_nxt;
  logic        busy_nxt;
  logic [4:0]  card;

  // Card built from the low five LFSR bits: colour is bits [4:3], number is
  // (bits [2:0] mod 5) + 1, giving 1,2,3,4,5,1,2,3 for 0..7.
  function automatic logic [4:0] make_card(input logic [4:0] bits);
    logic [2:0] number;
    number = 3'd1;
    case (bits[2:0])
      3'd0:    number = 3'd1;
      3'd1:    number = 3'd2;
      3'd2:    number = 3'd3;
      3'd3:    number = 3'd4;
      3'd4:    number = 3'd5;
      3'd5:    number = 3'd1;
      3'd6:    number = 3'd2;
      3'd7:    number = 3'd3;
      default: number = 3'd1;
    endcase
    return {bits[4:3], number};
  endfunction

  assign card = make_card(lfsr[4:0]);

  // Saturating decrement so the deck count can never wrap below zero.
  assign cards_left_dec = (cards_left != 8'd0) ? (cards_left - 8'd1) : 8'd0;

  // Next-state and next-output logic for the dealing FSM.
  always_comb begin
    state_nxt         = state;
    timer_nxt         = timer;
    lfsr_nxt          = lfsr;
    value_player1_nxt = value_player1;
    value_player2_nxt = value_player2;
    random_enable_nxt = 1'b0;
    turn_nxt          = turn;
    cards_left_nxt    = cards_left;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt         = WAIT;
          timer_nxt         = TIMER_RELOAD;
          value_player1_nxt = 5'd0;
          value_player2_nxt = 5'd0;
          turn_nxt          = 1'b0;
          cards_left_nxt    = DECK_SIZE;
        end
      end

      WAIT: begin
        if (!hold) begin
          if (timer != 32'd0) begin
            timer_nxt = timer - 32'd1;
          end else begin
            state_nxt = DEAL;
          end
        end
      end

      DEAL: begin
        if (turn) begin
          value_player2_nxt = card;
        end else begin
          value_player1_nxt = card;
        end
        random_enable_nxt = 1'b1;
        turn_nxt          = ~turn;
        cards_left_nxt    = cards_left_dec;
        lfsr_nxt          = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        if (cards_left_dec == 8'd0) begin
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT;
          timer_nxt = TIMER_RELOAD;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Status flags are registered from the next state so they track the
    // state register exactly.
    busy_nxt       = (state_nxt == WAIT) || (state_nxt == DEAL);
    deck_empty_nxt = (state_nxt == DONE);
  end

  // State, timer, LFSR and all outputs registered; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      timer         <= 32'd0;
      lfsr          <= LFSR_INIT;
      value_player1 <= 5'd0;
      value_player2 <= 5'd0;
      random_enable <= 1'b0;
      turn          <= 1'b0;
      cards_left    <= DECK_SIZE;
      deck_empty    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      lfsr          <= lfsr_nxt;
      value_player1 <= value_player1_nxt;
      value_player2 <= value_player2_nxt;
      random_enable <= random_enable_nxt;
      turn          <= turn_nxt;
      cards_left    <= cards_left_nxt;
      deck_empty    <= deck_empty_nxt;
      busy          <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Purpose: directed checks of card_dealer timing, hold, deck exhaustion, restart, reset and card sequence.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: hold driven directly by the bench in directed windows.
module tb_card_dealer;

  logic clk;
  int   tests;
  int   fails;

  // Instance A: PERIOD=4, 56 cards, seed A5
  logic       rst_a, start_a, hold_a;
  logic [4:0] vp1_a, vp2_a;
  logic       re_a, turn_a, empty_a, busy_a;
  logic [7:0] left_a;

  // Instance B: PERIOD=2, 3 cards, seed A5
  logic       rst_b, start_b, hold_b;
  logic [4:0] vp1_b, vp2_b;
  logic       re_b, turn_b, empty_b, busy_b;
  logic [7:0] left_b;

  // Instance C: PERIOD=2, 2 cards, zero seed
  logic       rst_c, start_c, hold_c;
  logic [4:0] vp1_c, vp2_c;
  logic       re_c, turn_c, empty_c, busy_c;
  logic [7:0] left_c;

  card_dealer #(.PERIOD(4), .MAX_CARDS(56), .SEED(8'hA5)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .hold(hold_a),
    .value_player1(vp1_a), .value_player2(vp2_a), .random_enable(re_a),
    .turn(turn_a), .cards_left(left_a), .deck_empty(empty_a), .busy(busy_a)
  );

  card_dealer #(.PERIOD(2), .MAX_CARDS(3), .SEED(8'hA5)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .hold(hold_b),
    .value_player1(vp1_b), .value_player2(vp2_b), .random_enable(re_b),
    .turn(turn_b), .cards_left(left_b), .deck_empty(empty_b), .busy(busy_b)
  );

  card_dealer #(.PERIOD(2), .MAX_CARDS(2), .SEED(8'h00)) dut_c (
    .clk(clk), .rst(rst_c), .start(start_c), .hold(hold_c),
    .value_player1(vp1_c), .value_player2(vp2_c), .random_enable(re_c),
    .turn(turn_c), .cards_left(left_c), .deck_empty(empty_c), .busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference LFSR and card mapping used only for the long random run.
  function automatic logic [7:0] ref_lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [4:0] ref_card(input logic [7:0] l);
    logic [2:0] n;
    n = 3'(({29'd0, l[2:0]} % 32'd5) + 32'd1);
    return {l[4:3], n};
  endfunction

  initial begin
    int         cnt;
    int         deals;
    int         budget;
    logic [7:0] m_lfsr;
    logic       m_turn;
    logic [4:0] got;

    tests = 0;
    fails = 0;
    rst_a = 1'b0; start_a = 1'b0; hold_a = 1'b0;
    rst_b = 1'b0; start_b = 1'b0; hold_b = 1'b0;
    rst_c = 1'b0; start_c = 1'b0; hold_c = 1'b0;
    step();
    step();

    // Reset values
    chk("rst_vp1", 32'(vp1_a), 32'd0);
    chk("rst_vp2", 32'(vp2_a), 32'd0);
    chk("rst_re", 32'(re_a), 32'd0);
    chk("rst_turn", 32'(turn_a), 32'd0);
    chk("rst_left", 32'(left_a), 32'd56);
    chk("rst_empty", 32'(empty_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_left_c", 32'(left_c), 32'd2);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    step();

    // A: start at edge 0, first pulse at cycle 4
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("a_busy_c0", 32'(busy_a), 32'd1);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (re_a) cnt++;
    end
    chk("a_no_early_pulse", 32'(cnt), 32'd0);
    step();
    chk("a_re_c4", 32'(re_a), 32'd1);
    chk("a_vp1_c4", 32'(vp1_a), 32'h01);
    chk("a_vp2_c4", 32'(vp2_a), 32'h00);
    chk("a_turn_c4", 32'(turn_a), 32'd1);
    chk("a_left_c4", 32'(left_a), 32'd55);

    // start pulsed during WAIT (edges 5,6) must be ignored
    start_a = 1'b1;
    step();
    chk("a_re_c5", 32'(re_a), 32'd0);
    step();
    start_a = 1'b0;
    step();
    chk("a_re_c7", 32'(re_a), 32'd0);
    chk("a_left_c7", 32'(left_a), 32'd55);
    step();
    chk("a_re_c8", 32'(re_a), 32'd1);
    chk("a_vp1_c8", 32'(vp1_a), 32'h01);
    chk("a_vp2_c8", 32'(vp2_a), 32'h0B);
    chk("a_turn_c8", 32'(turn_a), 32'd0);
    chk("a_left_c8", 32'(left_a), 32'd54);

    // Three more deals at cycles 12, 16, 20
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (re_a) cnt++;
    end
    chk("a_pulses_9_20", 32'(cnt), 32'd3);
    chk("a_re_c20", 32'(re_a), 32'd1);
    chk("a_left_c20", 32'(left_a), 32'd51);

    // Reset during WAIT after 5 deals
    step();
    rst_a = 1'b0;
    step();
    rst_a = 1'b1;
    chk("a_mid_rst_vp1", 32'(vp1_a), 32'd0);
    chk("a_mid_rst_vp2", 32'(vp2_a), 32'd0);
    chk("a_mid_rst_turn", 32'(turn_a), 32'd0);
    chk("a_mid_rst_left", 32'(left_a), 32'd56);
    chk("a_mid_rst_busy", 32'(busy_a), 32'd0);
    chk("a_mid_rst_re", 32'(re_a), 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (re_a) cnt++;
    end
    chk("a_idle_no_pulse", 32'(cnt), 32'd0);
    chk("a_idle_busy", 32'(busy_a), 32'd0);

    // Restart after reset; hold sampled on edges 5..9
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int i = 0; i < 3; i++) step();
    step();
    chk("a2_re_c4", 32'(re_a), 32'd1);
    chk("a2_vp1_c4", 32'(vp1_a), 32'h01);
    hold_a = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (re_a) cnt++;
    end
    hold_a = 1'b0;
    chk("a2_vp1_held", 32'(vp1_a), 32'h01);
    chk("a2_vp2_held", 32'(vp2_a), 32'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      if (re_a) cnt++;
    end
    chk("a2_no_pulse_5_12", 32'(cnt), 32'd0);
    step();
    chk("a2_re_c13", 32'(re_a), 32'd1);
    chk("a2_vp2_c13", 32'(vp2_a), 32'h0B);
    chk("a2_vp1_c13", 32'(vp1_a), 32'h01);
    chk("a2_left_c13", 32'(left_a), 32'd54);

    // B: 3-card deck, PERIOD=2
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    step();
    chk("b_re_c1", 32'(re_b), 32'd0);
    step();
    chk("b_re_c2", 32'(re_b), 32'd1);
    chk("b_vp1_c2", 32'(vp1_b), 32'h01);
    chk("b_left_c2", 32'(left_b), 32'd2);
    step();
    step();
    chk("b_re_c4", 32'(re_b), 32'd1);
    chk("b_vp2_c4", 32'(vp2_b), 32'h0B);
    step();
    step();
    chk("b_re_c6", 32'(re_b), 32'd1);
    chk("b_vp1_c6", 32'(vp1_b), 32'h11);
    chk("b_left_c6", 32'(left_b), 32'd0);
    step();
    chk("b_empty_c7", 32'(empty_b), 32'd1);
    chk("b_busy_c7", 32'(busy_b), 32'd0);
    chk("b_vp1_c7", 32'(vp1_b), 32'h11);
    chk("b_vp2_c7", 32'(vp2_b), 32'h0B);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (re_b) cnt++;
    end
    chk("b_done_no_pulse", 32'(cnt), 32'd0);
    chk("b_left_done", 32'(left_b), 32'd0);

    // B restart from DONE: LFSR continues, cards cleared
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("b2_vp1_clr", 32'(vp1_b), 32'd0);
    chk("b2_vp2_clr", 32'(vp2_b), 32'd0);
    chk("b2_empty", 32'(empty_b), 32'd0);
    chk("b2_busy", 32'(busy_b), 32'd1);
    chk("b2_left", 32'(left_b), 32'd3);
    step();
    step();
    chk("b2_re_1", 32'(re_b), 32'd1);
    chk("b2_vp1_1", 32'(vp1_b), 32'h0B);
    step();
    step();
    chk("b2_re_2", 32'(re_b), 32'd1);
    chk("b2_vp2_2", 32'(vp2_b), 32'h15);
    step();
    step();
    chk("b2_re_3", 32'(re_b), 32'd1);
    step();
    chk("b2_empty_end", 32'(empty_b), 32'd1);

    // C: zero seed is forced to 8'h01
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    step();
    step();
    chk("c_re_c2", 32'(re_c), 32'd1);
    chk("c_vp1_c2", 32'(vp1_c), 32'h02);
    step();
    step();
    chk("c_vp2_c4", 32'(vp2_c), 32'h03);
    chk("c_left_c4", 32'(left_c), 32'd0);
    step();
    chk("c_empty_c5", 32'(empty_c), 32'd1);

    // B: 200 deals over repeated decks against the reference LFSR
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    m_lfsr = 8'hA5;
    m_turn = 1'b0;
    deals  = 0;
    budget = 0;
    start_b = 1'b1;
    while (deals < 200 && budget < 3000) begin
      step();
      budget++;
      if (start_b) begin
        start_b = 1'b0;
        m_turn  = 1'b0;
      end else if (empty_b) begin
        start_b = 1'b1;
      end
      if (re_b) begin
        got = m_turn ? vp2_b : vp1_b;
        chk("rnd_card", 32'(got), 32'(ref_card(m_lfsr)));
        chk("rnd_number_range", 32'((got[2:0] >= 3'd1) && (got[2:0] <= 3'd5)), 32'd1);
        m_lfsr = ref_lfsr_next(m_lfsr);
        chk("rnd_lfsr_nonzero", 32'(m_lfsr != 8'h00), 32'd1);
        m_turn = ~m_turn;
        deals++;
      end
    end
    chk("rnd_deal_count", 32'(deals), 32'd200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
